// File: rtl/riscv_lsu_if.sv
// Execute-stage request / data-memory bus bundle of the load/store unit.
// The slave modport is the LSU's view; master is the surrounding pipeline and memory.
interface riscv_lsu_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_WIDTH  = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [2:0]             req_funct3;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [WORD_LENGTH-1:0] req_wdata;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_we;
  logic [3:0]             mem_wstrb;
  logic [WORD_LENGTH-1:0] mem_wdata;
  logic                   mem_rsp_valid;
  logic [WORD_LENGTH-1:0] mem_rdata;
  logic                   rsp_valid;
  logic [WORD_LENGTH-1:0] rsp_data;
  logic                   lsu_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
           mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
           rsp_valid, rsp_data, lsu_err
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
           mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
           rsp_valid, rsp_data, lsu_err
  );
endinterface

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one request at a time, one word-aligned bus transaction,
// lane steering for stores and align/extend for loads.
module riscv_lsu #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input logic        clk,
  input logic        rst_n,
  riscv_lsu_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

  state_t                 r_state;
  logic                   r_we;
  logic [2:0]             r_funct3;
  logic [1:0]             r_off;
  logic                   r_req_ready;
  logic                   r_mem_req_valid;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic                   r_mem_we;
  logic [3:0]             r_mem_wstrb;
  logic [WORD_LENGTH-1:0] r_mem_wdata;
  logic                   r_rsp_valid;
  logic [WORD_LENGTH-1:0] r_rsp_data;
  logic                   r_lsu_err;

  logic [1:0]             w_off;
  logic                   w_illegal;
  logic [3:0]             w_wstrb;
  logic [WORD_LENGTH-1:0] w_wdata;
  logic [WORD_LENGTH-1:0] w_shifted;
  logic [WORD_LENGTH-1:0] w_load_data;

  assign w_off = bus.req_addr[1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_illegal = 1'b0;
    if (bus.req_we) w_illegal = (bus.req_funct3 > 3'b010);
    else            w_illegal = (bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
    case (bus.req_funct3[1:0])
      2'b01:   if (w_off[0])      w_illegal = 1'b1;
      2'b10:   if (w_off != 2'b00) w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Store data is replicated across lanes; the strobes pick which lanes memory keeps.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = '0;
    if (bus.req_we) begin
      case (bus.req_funct3[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << w_off;
          w_wdata = {4{bus.req_wdata[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << w_off;
          w_wdata = {2{bus.req_wdata[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = bus.req_wdata;
        end
      endcase
    end
  end

  assign w_shifted = bus.mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_data = '0;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load_data = w_shifted;
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_we            <= 1'b0;
      r_funct3        <= 3'b000;
      r_off           <= 2'b00;
      r_req_ready     <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_we        <= 1'b0;
      r_mem_wstrb     <= 4'b0000;
      r_mem_wdata     <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= '0;
      r_lsu_err       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_lsu_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_funct3    <= bus.req_funct3;
            r_off       <= w_off;
            r_req_ready <= 1'b0;
            if (w_illegal) begin
              r_state   <= ERR;
              r_lsu_err <= 1'b1;
            end else begin
              r_state         <= ISSUE;
              r_mem_req_valid <= 1'b1;
              r_mem_addr      <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
              r_mem_we        <= bus.req_we;
              r_mem_wstrb     <= w_wstrb;
              r_mem_wdata     <= w_wdata;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            r_state         <= WAIT;
            r_mem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_we ? '0 : w_load_data;
          end
        end
        RESP, ERR: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_wstrb     = r_mem_wstrb;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.lsu_err       = r_lsu_err;
endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed vector table, stall and reset sequences, and
// random requests checked against a byte-level reference model.
module tb_riscv_lsu;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  riscv_lsu_if #(.WORD_LENGTH(32), .ADDR_WIDTH(32)) lsu_bus ();

  riscv_lsu #(.WORD_LENGTH(32), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (lsu_bus)
  );

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_rsp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for an encoding with no size.
  function automatic int access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int n = access_size(f3);
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    return (addr % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int     n   = access_size(f3);
    int     off = addr % 4;
    longint v   = 0;
    for (int i = 0; i < n; i++) v += longint'(rdata[8*(off+i) +: 8]) << (8*i);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_wstrb(input bit we, input logic [2:0] f3,
                                             input logic [31:0] addr);
    logic [3:0] s = 4'b0000;
    int n   = access_size(f3);
    int off = addr % 4;
    if (we) for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + n);
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] d;
    int n = access_size(f3);
    for (int i = 0; i < 4; i++) d[8*i +: 8] = wdata[8*(i % n) +: 8];
    return d;
  endfunction

  task automatic do_txn(input string tag, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input bit e_err, input logic [31:0] e_addr, input logic [3:0] e_wstrb,
                        input logic [31:0] e_wdata, input logic [31:0] e_rsp,
                        input int n_ready_stall, input int n_rsp_stall);
    check({tag, " req_ready idle"}, lsu_bus.req_ready, 1);
    lsu_bus.req_valid  = 1'b1;
    lsu_bus.req_we     = we;
    lsu_bus.req_funct3 = f3;
    lsu_bus.req_addr   = addr;
    lsu_bus.req_wdata  = wdata;
    @(posedge clk); #1;
    lsu_bus.req_valid  = 1'b0;
    lsu_bus.req_addr   = $urandom;
    lsu_bus.req_wdata  = $urandom;
    if (e_err) begin
      check({tag, " lsu_err"}, lsu_bus.lsu_err, 1);
      check({tag, " err no bus"}, lsu_bus.mem_req_valid, 0);
      check({tag, " err no rsp"}, lsu_bus.rsp_valid, 0);
      @(posedge clk); #1;
      check({tag, " lsu_err pulse end"}, lsu_bus.lsu_err, 0);
      check({tag, " err no bus later"}, lsu_bus.mem_req_valid, 0);
      check({tag, " req_ready after err"}, lsu_bus.req_ready, 1);
      return;
    end
    for (int c = 0; c <= n_ready_stall; c++) begin
      check({tag, " mem_req_valid"}, lsu_bus.mem_req_valid, 1);
      check({tag, " mem_addr"}, lsu_bus.mem_addr, e_addr);
      check({tag, " mem_we"}, lsu_bus.mem_we, {31'd0, we});
      check({tag, " mem_wstrb"}, lsu_bus.mem_wstrb, e_wstrb);
      if (we) check({tag, " mem_wdata"}, lsu_bus.mem_wdata, e_wdata);
      check({tag, " req_ready busy"}, lsu_bus.req_ready, 0);
      lsu_bus.mem_req_ready = (c == n_ready_stall);
      lsu_bus.mem_rsp_valid = (c < n_ready_stall);
      @(posedge clk); #1;
      lsu_bus.mem_req_ready = 1'b0;
      lsu_bus.mem_rsp_valid = 1'b0;
    end
    for (int c = 0; c <= n_rsp_stall; c++) begin
      check({tag, " mem_req_valid wait"}, lsu_bus.mem_req_valid, 0);
      check({tag, " no early rsp"}, lsu_bus.rsp_valid, 0);
      check({tag, " req_ready wait"}, lsu_bus.req_ready, 0);
      if (c == n_rsp_stall) begin
        lsu_bus.mem_rsp_valid = 1'b1;
        lsu_bus.mem_rdata     = rdata;
      end
      @(posedge clk); #1;
      lsu_bus.mem_rsp_valid = 1'b0;
      lsu_bus.mem_rdata     = $urandom;
    end
    check({tag, " rsp_valid"}, lsu_bus.rsp_valid, 1);
    check({tag, " rsp_data"}, lsu_bus.rsp_data, e_rsp);
    @(posedge clk); #1;
    check({tag, " rsp_valid pulse end"}, lsu_bus.rsp_valid, 0);
    check({tag, " rsp_data held"}, lsu_bus.rsp_data, e_rsp);
    check({tag, " req_ready back"}, lsu_bus.req_ready, 1);
  endtask

  initial begin
    // we  f3    addr          wdata         rdata         err e_addr        strb     e_wdata       e_rsp
    vecs[0]  = '{0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{0, 3'd0, 32'h0000_0103, 32'h0,        32'h8012_3456, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{0, 3'd4, 32'h0000_0103, 32'h0,        32'h8012_3456, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[3]  = '{0, 3'd5, 32'h0000_0102, 32'h0,        32'h8012_3456, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_8012};
    vecs[4]  = '{0, 3'd1, 32'h0000_0102, 32'h0,        32'h8012_3456, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_8012};
    vecs[5]  = '{0, 3'd0, 32'h0000_0101, 32'h0,        32'h8012_3456, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0034};
    vecs[6]  = '{1, 3'd0, 32'h0000_0201, 32'h0000_00A5, 32'h1111_1111, 0, 32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[7]  = '{1, 3'd1, 32'h0000_0202, 32'h1234_BEEF, 32'h0,        0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[8]  = '{1, 3'd2, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,        0, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[9]  = '{1, 3'd1, 32'h0000_0203, 32'h0,        32'h0,        1, 32'h0,         4'b0000, 32'h0,        32'h0};
    vecs[10] = '{0, 3'd3, 32'h0000_0100, 32'h0,        32'h0,        1, 32'h0,         4'b0000, 32'h0,        32'h0};
    vecs[11] = '{0, 3'd2, 32'h0000_0102, 32'h0,        32'h0,        1, 32'h0,         4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1, 3'd4, 32'h0000_0200, 32'h0,        32'h0,        1, 32'h0,         4'b0000, 32'h0,        32'h0};
    vecs[13] = '{0, 3'd5, 32'h0000_0101, 32'h0,        32'h0,        1, 32'h0,         4'b0000, 32'h0,        32'h0};

    rst_n                 = 1'b0;
    lsu_bus.req_valid     = 1'b0;
    lsu_bus.req_we        = 1'b0;
    lsu_bus.req_funct3    = 3'd0;
    lsu_bus.req_addr      = 32'h0;
    lsu_bus.req_wdata     = 32'h0;
    lsu_bus.mem_req_ready = 1'b0;
    lsu_bus.mem_rsp_valid = 1'b0;
    lsu_bus.mem_rdata     = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", lsu_bus.req_ready, 1);
    check("reset mem_req_valid", lsu_bus.mem_req_valid, 0);
    check("reset mem_wstrb", lsu_bus.mem_wstrb, 0);
    check("reset rsp_valid", lsu_bus.rsp_valid, 0);
    check("reset lsu_err", lsu_bus.lsu_err, 0);
    check("reset rsp_data", lsu_bus.rsp_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdata, vecs[i].err, vecs[i].e_addr, vecs[i].e_wstrb, vecs[i].e_wdata,
             vecs[i].e_rsp, 0, 0);

    // Bus stall: ready held off 3 cycles, response 2 cycles after the handshake.
    do_txn("stall", 1'b0, 3'd2, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 1'b0, 32'h0000_0300,
           4'b0000, 32'h0, 32'h1357_9BDF, 3, 2);

    // Reset while a load is waiting for its response.
    lsu_bus.req_valid  = 1'b1;
    lsu_bus.req_we     = 1'b0;
    lsu_bus.req_funct3 = 3'd2;
    lsu_bus.req_addr   = 32'h0000_0400;
    @(posedge clk); #1;
    lsu_bus.req_valid     = 1'b0;
    lsu_bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    lsu_bus.mem_req_ready = 1'b0;
    check("rst_seq in wait", lsu_bus.mem_req_valid, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_seq req_ready", lsu_bus.req_ready, 1);
    check("rst_seq mem_req_valid", lsu_bus.mem_req_valid, 0);
    check("rst_seq mem_addr", lsu_bus.mem_addr, 0);
    check("rst_seq mem_we", lsu_bus.mem_we, 0);
    check("rst_seq mem_wstrb", lsu_bus.mem_wstrb, 0);
    check("rst_seq mem_wdata", lsu_bus.mem_wdata, 0);
    check("rst_seq rsp_data", lsu_bus.rsp_data, 0);
    check("rst_seq rsp_valid", lsu_bus.rsp_valid, 0);
    check("rst_seq lsu_err", lsu_bus.lsu_err, 0);
    lsu_bus.mem_rsp_valid = 1'b1;
    lsu_bus.mem_rdata     = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    lsu_bus.mem_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("stray rsp no rsp_valid", lsu_bus.rsp_valid, 0);
      check("stray rsp req_ready", lsu_bus.req_ready, 1);
      @(posedge clk); #1;
    end

    for (int t = 0; t < 300; t++) begin
      bit          we    = 1'($urandom_range(0, 1));
      logic [2:0]  f3    = 3'($urandom_range(0, 7));
      logic [31:0] addr  = 32'h0000_1000 + $urandom_range(0, 1023);
      logic [31:0] wdata = $urandom;
      logic [31:0] rdata = $urandom;
      bit          err   = model_err(we, f3, addr);
      logic [31:0] rsp   = we ? 32'h0 : model_load(f3, addr, rdata);
      if (!err && we) f3 = f3;
      do_txn($sformatf("rand%0d", t), we, f3, addr, wdata, rdata, err, (addr / 4) * 4,
             model_wstrb(we, f3, addr), err ? 32'h0 : model_wdata(f3, wdata), rsp,
             $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
